// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (fetch / LSU) arbiter in front of a single data-memory
// port. Round-robin on ties, one outstanding transaction, optional wait timeout
// that completes the owner with an error flag.
//
// Handshake: a port raises pX_valid with a stable payload and holds both until
// the cycle pX_ready is high; pX_ready is a one-cycle completion pulse, and
// pX_err qualifies it. Downstream, m_valid is held with a stable payload until
// s_ready completes it; s_ready while m_valid is low is ignored. A port that
// drops valid before its ready withdraws its request (flush).
//
// The FSM state is exposed directly: busy is high exactly in BUSY, and grant
// shows the registered owner while BUSY.
module dmem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_wstrb,
  output logic          p0_ready,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_valid,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_wstrb,
  output logic          p1_ready,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          m_valid,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wstrb,
  input  logic          s_ready,
  input  logic [31:0]   s_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter only has to reach TIMEOUT-1; with the timeout disabled it just
  // saturates, so a single bit is enough.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0]   CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  logic [0:0]    state_q, state_d;
  logic          owner_q, owner_d;      // 0 = port 0, 1 = port 1
  logic          last_q, last_d;        // last port that completed
  logic [CW-1:0] cnt_q, cnt_d;

  logic own_valid;
  logic in_busy;
  logic done_ok;
  logic timeout_hit;
  logic complete;

  // Completion decode for the current owner; s_ready beats the timeout.
  always_comb begin
    in_busy     = (state_q == S_BUSY);
    own_valid   = owner_q ? p1_valid : p0_valid;
    done_ok     = in_busy && own_valid && s_ready;
    timeout_hit = TO_EN && in_busy && own_valid && !s_ready && (cnt_q == CNT_LAST);
    complete    = done_ok || timeout_hit;
  end

  // Output mux: everything is zero outside BUSY, payload follows the owner.
  always_comb begin
    p0_ready = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ready = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    grant    = 2'b00;
    busy     = 1'b0;
    if (in_busy) begin
      busy    = 1'b1;
      grant   = owner_q ? 2'b10 : 2'b01;
      m_valid = own_valid;
      m_addr  = owner_q ? p1_addr  : p0_addr;
      m_wdata = owner_q ? p1_wdata : p0_wdata;
      m_wstrb = owner_q ? p1_wstrb : p0_wstrb;
      if (owner_q) begin
        p1_ready = complete;
        p1_err   = timeout_hit;
        p1_rdata = done_ok ? s_rdata : '0;
      end else begin
        p0_ready = complete;
        p0_err   = timeout_hit;
        p0_rdata = done_ok ? s_rdata : '0;
      end
    end
  end

  // Next-state: arbitrate in IDLE, finish / flush / count in BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (p0_valid || p1_valid) begin
        state_d = S_BUSY;
        owner_d = (p0_valid && p1_valid) ? ~last_q : p1_valid;
        cnt_d   = '0;
      end
    end else begin
      if (!own_valid) begin
        // Owner withdrew: drop back without touching round-robin history.
        state_d = S_IDLE;
      end else if (complete) begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset leaves port 0 as the first tie winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written flush/reset
// sequence, then constrained-random traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam int TO = 4;

  typedef struct packed {
    logic [1:0]  grant;
    logic        busy;
    logic        mv;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic        p0r;
    logic        p0e;
    logic [31:0] p0d;
    logic        p1r;
    logic        p1e;
    logic [31:0] p1d;
  } out_t;

  typedef struct packed {
    logic        p0v;
    logic        p1v;
    logic [31:0] p0a;
    logic [31:0] p1a;
    logic        sr;
    logic [31:0] srd;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] P0_WD = 32'h0000_AAAA;
  localparam logic [3:0]  P0_WS = 4'b0011;
  localparam logic [31:0] P1_WD = 32'h0000_5555;
  localparam logic [3:0]  P1_WS = 4'b0000;

  logic        clk;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ready, p1_ready, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_vec;
  int n_miss;

  dmem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s %s: got %h expected %h", tag, f, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    n_vec++;
    cmp(tag, "grant",    32'(grant),    32'(e.grant));
    cmp(tag, "busy",     32'(busy),     32'(e.busy));
    cmp(tag, "m_valid",  32'(m_valid),  32'(e.mv));
    cmp(tag, "p0_ready", 32'(p0_ready), 32'(e.p0r));
    cmp(tag, "p0_err",   32'(p0_err),   32'(e.p0e));
    cmp(tag, "p0_rdata", p0_rdata,      e.p0d);
    cmp(tag, "p1_ready", 32'(p1_ready), 32'(e.p1r));
    cmp(tag, "p1_err",   32'(p1_err),   32'(e.p1e));
    cmp(tag, "p1_rdata", p1_rdata,      e.p1d);
    if (e.mv) begin
      cmp(tag, "m_addr",  m_addr,        e.maddr);
      cmp(tag, "m_wdata", m_wdata,       e.mwdata);
      cmp(tag, "m_wstrb", 32'(m_wstrb),  32'(e.mwstrb));
    end
  endtask

  // Expected outputs for the owner port g (2'b01 / 2'b10) or idle (2'b00).
  function automatic out_t mk_out(input logic [1:0] g, input logic mv, input logic [31:0] a,
                                  input logic p0r, input logic p0e, input logic [31:0] p0d,
                                  input logic p1r, input logic p1e, input logic [31:0] p1d);
    out_t o;
    o = '0;
    o.grant  = g;
    o.busy   = (g != 2'b00);
    o.mv     = mv;
    o.maddr  = a;
    o.mwdata = (g == 2'b01) ? P0_WD : P1_WD;
    o.mwstrb = (g == 2'b01) ? P0_WS : P1_WS;
    o.p0r = p0r; o.p0e = p0e; o.p0d = p0d;
    o.p1r = p1r; o.p1e = p1e; o.p1d = p1d;
    return o;
  endfunction

  function automatic vec_t mk(input logic p0v, input logic p1v, input logic [31:0] p0a,
                              input logic [31:0] p1a, input logic sr, input logic [31:0] srd,
                              input logic [1:0] g,
                              input logic p0r, input logic p0e, input logic [31:0] p0d,
                              input logic p1r, input logic p1e, input logic [31:0] p1d);
    vec_t v;
    v.p0v = p0v; v.p1v = p1v; v.p0a = p0a; v.p1a = p1a; v.sr = sr; v.srd = srd;
    v.exp = mk_out(g, (g == 2'b01) ? p0v : (g == 2'b10) ? p1v : 1'b0,
                   (g == 2'b01) ? p0a : p1a, p0r, p0e, p0d, p1r, p1e, p1d);
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic p0v, input logic p1v, input logic [31:0] p0a,
                       input logic [31:0] p1a, input logic sr, input logic [31:0] srd);
    p0_valid = p0v; p0_addr = p0a; p0_wdata = P0_WD; p0_wstrb = P0_WS;
    p1_valid = p1v; p1_addr = p1a; p1_wdata = P1_WD; p1_wstrb = P1_WS;
    s_ready  = sr;  s_rdata = srd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_out("reset", '0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit mdl_busy;
  int mdl_owner;
  int mdl_stall;   // BUSY cycles already spent waiting on this transaction
  int mdl_last;

  function automatic void mdl_reset();
    mdl_busy = 0; mdl_owner = 0; mdl_stall = 0; mdl_last = 1;
  endfunction

  function automatic out_t mdl_out();
    out_t e;
    logic        v[2];
    logic [31:0] a[2], wd[2];
    logic [3:0]  ws[2];
    bit ok, to;
    e = '0;
    v[0] = p0_valid; v[1] = p1_valid;
    a[0] = p0_addr;  a[1] = p1_addr;
    wd[0] = p0_wdata; wd[1] = p1_wdata;
    ws[0] = p0_wstrb; ws[1] = p1_wstrb;
    if (mdl_busy) begin
      ok = v[mdl_owner] && s_ready;
      to = v[mdl_owner] && !s_ready && (TO > 0) && (mdl_stall + 1 == TO);
      e.busy   = 1'b1;
      e.grant  = 2'(1 << mdl_owner);
      e.mv     = v[mdl_owner];
      e.maddr  = a[mdl_owner];
      e.mwdata = wd[mdl_owner];
      e.mwstrb = ws[mdl_owner];
      if (mdl_owner == 0) begin
        e.p0r = ok || to; e.p0e = to; e.p0d = ok ? s_rdata : 32'h0;
      end else begin
        e.p1r = ok || to; e.p1e = to; e.p1d = ok ? s_rdata : 32'h0;
      end
    end
    return e;
  endfunction

  function automatic void mdl_step();
    logic v[2];
    bit fin;
    v[0] = p0_valid; v[1] = p1_valid;
    if (!mdl_busy) begin
      if (v[0] || v[1]) begin
        mdl_busy  = 1;
        mdl_owner = (v[0] && v[1]) ? 1 - mdl_last : (v[1] ? 1 : 0);
        mdl_stall = 0;
      end
    end else if (!v[mdl_owner]) begin
      mdl_busy = 0;
    end else begin
      fin = s_ready || ((TO > 0) && (mdl_stall + 1 == TO));
      if (fin) begin
        mdl_busy = 0;
        mdl_last = mdl_owner;
      end else begin
        mdl_stall++;
      end
    end
  endfunction

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    bit          hold0, hold1;
    logic [31:0] a0, a1;
    bit          seen_r0, seen_r1;
    n_vec  = 0;
    n_miss = 0;

    // Directed table, starting from reset (port 0 wins the first tie).
    tbl.push_back(mk(0, 1, 0, 32'h100, 0, 0,             2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h100, 1, 32'hDEADBEEF,  2'b10, 0, 0, 0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                   2'b00, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1, 1, 32'h200, 32'h300, 1, 32'h11111111, 2'b00, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h200, 32'h300, 1, 32'h11111111, 2'b01, 1, 0, 32'h11111111, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h200, 32'h300, 1, 32'h11111111, 2'b00, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h200, 32'h300, 1, 32'h11111111, 2'b10, 0, 0, 0, 1, 0, 32'h11111111));
    end
    // Timeout after four stalled BUSY cycles, rdata forced to zero.
    tbl.push_back(mk(1, 0, 32'h400, 0, 0, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 32'h400, 0, 0, 32'h12345678, 2'b01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h400, 0, 0, 32'h12345678, 2'b01, 1, 1, 0, 0, 0, 0));
    // s_ready arriving on the timeout cycle wins.
    tbl.push_back(mk(1, 0, 32'h500, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 32'h500, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h500, 0, 1, 32'hCAFEF00D, 2'b01, 1, 0, 32'hCAFEF00D, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].p0v, tbl[i].p1v, tbl[i].p0a, tbl[i].p1a, tbl[i].sr, tbl[i].srd);
      @(negedge clk);
      check_out($sformatf("tbl%0d", i), tbl[i].exp);
      next_cycle();
    end

    // Flush: p1 withdraws in BUSY; last winner stays p0, so the next tie goes to p1.
    drive(0, 1, 0, 32'h600, 0, 0);
    @(negedge clk); check_out("flush_idle", '0);
    next_cycle();
    drive(0, 0, 0, 32'h600, 1, 32'h77777777);
    @(negedge clk); check_out("flush_busy", mk_out(2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(1, 1, 32'h700, 32'h800, 0, 0);
    @(negedge clk); check_out("flush_back_idle", '0);
    next_cycle();
    @(negedge clk); check_out("flush_tie_p1", mk_out(2'b10, 1, 32'h800, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset in BUSY: outputs drop at once, then p0 wins the tie.
    rst_n = 1'b0;
    #1 check_out("rst_async", '0);
    next_cycle();
    check_out("rst_held", '0);
    rst_n = 1'b1;
    @(negedge clk); check_out("rst_rel_idle", '0);
    next_cycle();
    @(negedge clk); check_out("rst_tie_p0", mk_out(2'b01, 1, 32'h700, 0, 0, 0, 0, 0, 0));
    next_cycle();

    // Random traffic against the model.
    do_reset();
    mdl_reset();
    hold0 = 0; hold1 = 0; seen_r0 = 0; seen_r1 = 0; a0 = 0; a1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seen_r0) hold0 = 0;
      if (seen_r1) hold1 = 0;
      if (!hold0 && $urandom_range(0, 2) == 0) begin
        hold0 = 1; a0 = $urandom;
        p0_wdata = $urandom; p0_wstrb = 4'($urandom_range(0, 15));
      end else if (hold0 && $urandom_range(0, 40) == 0) begin
        hold0 = 0;
      end
      if (!hold1 && $urandom_range(0, 2) == 0) begin
        hold1 = 1; a1 = $urandom;
        p1_wdata = $urandom; p1_wstrb = 4'($urandom_range(0, 15));
      end else if (hold1 && $urandom_range(0, 40) == 0) begin
        hold1 = 0;
      end
      p0_valid = hold0; p0_addr = a0;
      p1_valid = hold1; p1_addr = a1;
      s_ready  = ($urandom_range(0, 3) == 0);
      s_rdata  = $urandom;
      @(negedge clk);
      check_out($sformatf("rnd%0d", c), mdl_out());
      seen_r0 = p0_ready;
      seen_r1 = p1_ready;
      mdl_step();
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles BUSY may wait for downstream ready before error completion; 0 disables the timeout.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 p0_valid / p1_valid  input  1  port 0 (fetch) / port 1 (LSU) request; the requester holds it and its payload stable until its ready.
REQ-006 p0_addr / p1_addr  input  AW  request address.
REQ-007 p0_wdata / p1_wdata  input  32  store data.
REQ-008 p0_wstrb / p1_wstrb  input  4  byte strobes; 4'b0000 means read.
REQ-009 p0_ready / p1_ready  output  1  one-cycle completion pulse to the port.
REQ-010 p0_rdata / p1_rdata  output  32  read data, valid only while the matching ready is high, else 0.
REQ-011 p0_err / p1_err  output  1  completion was a timeout; qualifies ready.
REQ-012 m_valid  output  1  downstream request.
REQ-013 m_addr / m_wdata / m_wstrb  output  AW/32/4  downstream payload muxed from the owner port.
REQ-014 s_ready  input  1  downstream completion; s_rdata valid the same cycle.
REQ-015 s_rdata  input  32  downstream read data.
REQ-016 grant  output  2  one-hot owner ({p1,p0}); 2'b00 when IDLE.
REQ-017 busy  output  1  high in state BUSY.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE, BUSY.
REQ-019 In IDLE, a single valid port SHALL be registered as owner and the FSM SHALL enter BUSY next cycle.
REQ-020 In IDLE with both ports valid, the port not equal to last_winner SHALL win (round-robin).
REQ-021 In IDLE, m_valid, all port readies and grant SHALL be 0, giving 1 cycle arbitration latency.
REQ-022 In BUSY, m_valid SHALL equal the owner's valid, and m_addr/m_wdata/m_wstrb SHALL equal the owner's payload combinationally.
REQ-023 In BUSY, the non-owner port SHALL see ready=0 regardless of its valid.
REQ-024 In BUSY with m_valid and s_ready, the owner SHALL get ready=1, rdata=s_rdata and err=0 that cycle; the FSM SHALL enter IDLE and last_winner SHALL be set to the owner.
REQ-025 Peak throughput SHALL be one transaction per 2 cycles (IDLE cycle plus BUSY completion cycle).
REQ-026 A wait counter SHALL clear on IDLE->BUSY and increment on each BUSY cycle without s_ready.
REQ-027 If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with s_ready=0, the owner SHALL get ready=1, err=1, rdata=0; the FSM SHALL enter IDLE and last_winner SHALL update.
REQ-028 s_ready and timeout in the same cycle: s_ready SHALL take precedence (err=0, real data).
REQ-029 If the owner drops valid in BUSY (flush), the FSM SHALL return to IDLE next cycle with no ready pulse and m_valid=0 that cycle; last_winner SHALL be unchanged.
REQ-030 s_ready while m_valid=0 SHALL be ignored.
REQ-031 The wait counter SHALL be wide enough for TIMEOUT and SHALL saturate without wrapping when TIMEOUT=0.

Reset
REQ-032 While rst_n is low, the FSM SHALL be IDLE, last_winner=1 (port 0 wins first tie), and the counter 0.
REQ-033 While rst_n is low, all outputs SHALL be 0.
REQ-034 Reset asserted in BUSY SHALL abort the transaction immediately with no ready pulse.

Verification
REQ-035 Single read: p1_valid, addr 0x100, wstrb 0 -> cycle 1 m_valid, grant=2'b10; s_ready with s_rdata 0xDEADBEEF -> p1_ready=1, p1_rdata=0xDEADBEEF, p1_err=0.
REQ-036 Contention after reset: both ports valid and held -> order p0, p1, p0, p1, one completion per 2 cycles while s_ready stays high.
REQ-037 Timeout: TIMEOUT=4, owner p0, s_ready held 0 -> p0_ready=p0_err=1 on the 4th BUSY cycle, p0_rdata=0, then IDLE.
REQ-038 Same-cycle s_ready and timeout -> err=0, data forwarded.
REQ-039 Flush and reset: p1 drops valid in BUSY -> IDLE, no p1_ready, last_winner unchanged; rst_n pulsed low in BUSY -> all outputs 0, next tie grants p0.
